// File: rtl/aim_pkg.sv
`default_nettype none
// ============================================================================
// aim_pkg : shared types, angle limits and slew helpers for the aim sequencer
// Revision: 1.0
// ============================================================================
package aim_pkg;

    typedef logic [10:0] angle_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SLEW     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_FIRE     = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    localparam angle_t ANG_MIN    = 11'd600;
    localparam angle_t ANG_MAX    = 11'd2000;
    localparam angle_t ANG_CENTER = 11'd1300;

    function automatic angle_t clamp_angle(input angle_t a);
        if (a < ANG_MIN)      return ANG_MIN;
        else if (a > ANG_MAX) return ANG_MAX;
        else                  return a;
    endfunction

    // Differences are formed only in the safe direction, so no wrap can occur.
    function automatic angle_t step_toward(input angle_t cur, input angle_t tgt,
                                           input angle_t step);
        angle_t diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > step) ? cur + step : tgt;
        end else begin
            diff = cur - tgt;
            return (diff > step) ? cur - step : tgt;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/period_tick.sv
`default_nettype none
// ============================================================================
// period_tick : one-cycle pulse every TICK_CYCLES clocks, free-running counter
// Revision: 1.0
// ============================================================================
module period_tick #(
    parameter int TICK_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                   cnt_q <= cnt_q + CW'(1);
    end

    assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/aim_sequencer.sv
`default_nettype none
// ============================================================================
// aim_sequencer : rate-limited pan/tilt slew, settle, timed fire and cooldown
// Revision: 1.0
// ============================================================================
module aim_sequencer
    import aim_pkg::*;
#(
    parameter int clock_frequency_mhz = 50,
    parameter int TICK_US             = 20000,
    parameter int STEP                = 16,
    parameter int SETTLE_TICKS        = 10,
    parameter int FIRE_TICKS          = 3,
    parameter int COOL_TICKS          = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [10:0] tgt_pan,
    input  logic [10:0] tgt_tilt,
    input  logic        tgt_fire,
    input  logic        on_screen,
    output logic [10:0] pan_angle,
    output logic [10:0] tilt_angle,
    output logic        fire,
    output logic        busy,
    output logic [2:0]  state
);

    localparam int TICK_CYCLES = clock_frequency_mhz * TICK_US;
    localparam int FIRE_CYCLES = FIRE_TICKS * TICK_CYCLES;
    localparam int M1          = (SETTLE_TICKS > COOL_TICKS) ? SETTLE_TICKS : COOL_TICKS;
    localparam int CNT_MAX     = (FIRE_CYCLES > M1) ? FIRE_CYCLES : M1;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] FIRE_LAST   = CNT_W'(FIRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOL_TICKS - 1);
    localparam angle_t           STEP_A      = angle_t'(STEP);

    state_t           state_q, state_d;
    angle_t           pan_q, pan_d, tilt_q, tilt_d;
    angle_t           pan_tgt_q, pan_tgt_d, tilt_tgt_q, tilt_tgt_d;
    logic             fire_req_q, fire_req_d;
    logic             fire_q, fire_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             accept;

    period_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pan_q      <= ANG_CENTER;
            tilt_q     <= ANG_CENTER;
            pan_tgt_q  <= ANG_CENTER;
            tilt_tgt_q <= ANG_CENTER;
            fire_req_q <= 1'b0;
            fire_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pan_q      <= pan_d;
            tilt_q     <= tilt_d;
            pan_tgt_q  <= pan_tgt_d;
            tilt_tgt_q <= tilt_tgt_d;
            fire_req_q <= fire_req_d;
            fire_q     <= fire_d;
            cnt_q      <= cnt_d;
        end
    end

    assign accept = tgt_valid && tgt_ready;

    always_comb begin
        state_d    = state_q;
        pan_d      = pan_q;
        tilt_d     = tilt_q;
        pan_tgt_d  = pan_tgt_q;
        tilt_tgt_d = tilt_tgt_q;
        fire_req_d = fire_req_q;
        cnt_d      = cnt_q;

        if (accept) begin
            pan_tgt_d  = clamp_angle(tgt_pan);
            tilt_tgt_d = clamp_angle(tgt_tilt);
            fire_req_d = tgt_fire;
            state_d    = ST_SLEW;
        end

        case (state_q)
            ST_IDLE: ;
            ST_SLEW: begin
                // An accept suppresses this cycle's step; the next tick uses the new target.
                if (!accept) begin
                    if (pan_q == pan_tgt_q && tilt_q == tilt_tgt_q) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        pan_d  = step_toward(pan_q, pan_tgt_q, STEP_A);
                        tilt_d = step_toward(tilt_q, tilt_tgt_q, STEP_A);
                    end
                end
            end
            ST_SETTLE: begin
                if (!accept && tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = (fire_req_q && on_screen) ? ST_FIRE : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FIRE: begin
                if (!on_screen || cnt_q == FIRE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_COOLDOWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cnt_q == COOL_LAST) begin
                        cnt_d      = '0;
                        fire_req_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fire_d = (state_d == ST_FIRE);
    end

    always_comb begin
        tgt_ready = (state_q == ST_IDLE) || (state_q == ST_SLEW) || (state_q == ST_SETTLE);
        busy      = (state_q != ST_IDLE);
    end

    assign pan_angle  = pan_q;
    assign tilt_angle = tilt_q;
    assign fire       = fire_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_aim_sequencer.sv
`default_nettype none
// ============================================================================
// tb_aim_sequencer : directed bench for aim_sequencer (tick every 10 cycles)
// Revision: 1.0
// ============================================================================
module tb_aim_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tgt_valid = 1'b0;
    logic        tgt_ready;
    logic [10:0] tgt_pan = '0;
    logic [10:0] tgt_tilt = '0;
    logic        tgt_fire = 1'b0;
    logic        on_screen = 1'b0;
    logic [10:0] pan_angle, tilt_angle;
    logic        fire, busy;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int tb_cnt;

    aim_sequencer #(
        .clock_frequency_mhz (1),
        .TICK_US             (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_pan    (tgt_pan),
        .tgt_tilt   (tgt_tilt),
        .tgt_fire   (tgt_fire),
        .on_screen  (on_screen),
        .pan_angle  (pan_angle),
        .tilt_angle (tilt_angle),
        .fire       (fire),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference tick phase: a tick lands on the edge where tb_cnt reads 9.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 9) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick();
        forever begin
            @(negedge clk);
            if (tb_cnt == 9) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] p, input logic [10:0] t, input logic f);
        @(negedge clk);
        check("ready_before_accept", tgt_ready, 1);
        tgt_pan   = p;
        tgt_tilt  = t;
        tgt_fire  = f;
        tgt_valid = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, state, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic bad;

        // Reset values
        cyc(3);
        @(negedge clk);
        check("rst_pan", pan_angle, 1300);
        check("rst_tilt", tilt_angle, 1300);
        check("rst_fire", fire, 0);
        check("rst_ready", tgt_ready, 1);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Plain slew 1300 -> 1340 in three ticks, then settle and back to idle
        send(11'd1340, 11'd1300, 1'b0);
        check("slew_state", state, 1);
        check("slew_busy", busy, 1);
        wait_tick();
        check("slew_pan1", pan_angle, 1316);
        wait_tick();
        check("slew_pan2", pan_angle, 1332);
        wait_tick();
        check("slew_pan3", pan_angle, 1340);
        check("slew_tilt", tilt_angle, 1300);
        cyc(1);
        check("settle_enter", state, 2);
        repeat (9) wait_tick();
        check("settle_hold", state, 2);
        wait_tick();
        check("settle_to_idle", state, 0);

        // Clamping: requests beyond the limits end at 2000 / 600
        send(11'd2047, 11'd100, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            wait_tick();
            if (pan_angle > 11'd2000 || pan_angle < 11'd600 ||
                tilt_angle > 11'd2000 || tilt_angle < 11'd600) bad = 1'b1;
        end
        check("clamp_in_range", bad, 0);
        check("clamp_pan", pan_angle, 2000);
        check("clamp_tilt", tilt_angle, 600);
        wait_state(3'd0, 300, "clamp_idle");

        // Firing: 30 cycles of fire, then 25 cooldown ticks
        on_screen = 1'b1;
        send(11'd2000, 11'd616, 1'b1);
        wait_state(3'd3, 400, "fire_enter");
        check("fire_high", fire, 1);
        check("fire_ready", tgt_ready, 0);
        n = 0;
        while (fire === 1'b1 && n < 100) begin
            n++;
            cyc(1);
        end
        check("fire_len", n, 30);
        check("cool_state", state, 4);
        check("cool_ready", tgt_ready, 0);
        n = 0;
        while (state === 3'd4 && n < 40) begin
            wait_tick();
            n++;
        end
        check("cool_ticks", n, 25);
        check("cool_idle", state, 0);
        check("cool_ready_back", tgt_ready, 1);

        // on_screen lost during FIRE
        send(11'd2000, 11'd632, 1'b1);
        wait_state(3'd3, 400, "abort_enter");
        cyc(5);
        check("abort_fire_pre", fire, 1);
        @(negedge clk);
        on_screen = 1'b0;
        @(posedge clk);
        #1;
        check("abort_fire", fire, 0);
        check("abort_state", state, 4);
        wait_state(3'd0, 400, "abort_idle");
        on_screen = 1'b1;

        // Retarget mid-slew
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(11'd1500, 11'd1300, 1'b0);
        wait_tick();
        wait_tick();
        check("retgt_pan_pre", pan_angle, 1332);
        send(11'd1200, 11'd1300, 1'b0);
        wait_tick();
        check("retgt_pan_step", pan_angle, 1316);
        wait_state(3'd2, 200, "retgt_settle");
        check("retgt_pan_end", pan_angle, 1200);
        wait_state(3'd0, 200, "retgt_idle");

        // Asynchronous reset mid-slew
        send(11'd1500, 11'd1400, 1'b0);
        wait_tick();
        wait_tick();
        check("mid_slew_state", state, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pan", pan_angle, 1300);
        check("arst_tilt", tilt_angle, 1300);
        check("arst_state", state, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", tgt_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        cyc(30);
        check("arst_stay_idle", state, 0);
        check("arst_pan_hold", pan_angle, 1300);

        // Reset during FIRE leaves no residual pulse
        send(11'd1316, 11'd1300, 1'b1);
        wait_state(3'd3, 400, "rfire_enter");
        cyc(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rfire_fire", fire, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (fire !== 1'b0) bad = 1'b1;
        end
        check("rfire_no_pulse", bad, 0);
        check("rfire_state", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
